// File: rtl/dk_sound_trigger_latch_if.sv
// CPU-side bus of the sound trigger latch: write strobe, bit address/data,
// latch clear and the raw latch readback.
interface dk_sound_trigger_latch_if;
  logic       cpu_wr;
  logic [2:0] cpu_addr;
  logic       cpu_data;
  logic       latch_clr;
  logic [7:0] latch_q;

  modport master (
    output cpu_wr, cpu_addr, cpu_data, latch_clr,
    input  latch_q
  );

  modport slave (
    input  cpu_wr, cpu_addr, cpu_data, latch_clr,
    output latch_q
  );
endinterface

// File: rtl/dk_sound_trigger_latch.sv
// 74LS259-style sound latch plus per-bit trigger conditioning: every rising
// edge gives a minimum-length audible pulse and every fall a minimum gap.
module dk_sound_trigger_latch #(
  parameter int unsigned CLOCK_RATE       = 1000000,
  parameter int unsigned SAMPLE_RATE      = 48000,
  parameter int unsigned MIN_HOLD_SAMPLES = 48,
  parameter int unsigned MIN_GAP_SAMPLES  = 24,
  parameter int unsigned WALK_BIT         = 0
) (
  input  logic                     clk,
  input  logic                     I_RSTn,
  input  logic                     audio_clk_en,
  dk_sound_trigger_latch_if.slave  cpu,
  output logic [7:0]               trig_out,
  output logic                     walk_en
);

  localparam int unsigned CNT_MAX = (MIN_HOLD_SAMPLES > MIN_GAP_SAMPLES) ?
                                    MIN_HOLD_SAMPLES : MIN_GAP_SAMPLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD_SAMPLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(MIN_GAP_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       WALK_IDX  = 3'(WALK_BIT);

  if (MIN_HOLD_SAMPLES < 1 || MIN_GAP_SAMPLES < 1 || WALK_BIT > 7 ||
      SAMPLE_RATE > CLOCK_RATE) begin : g_bad_params
    $error("dk_sound_trigger_latch: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_FOLLOW,
    ST_GAP
  } ch_state_e;

  logic [7:0]       latch_bits_q, latch_bits_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       trig_q, trig_d;
  logic [7:0]       consume;
  ch_state_e        state_q [8];
  ch_state_e        state_d [8];
  logic [CNT_W-1:0] cnt_q   [8];
  logic [CNT_W-1:0] cnt_d   [8];

  // Channel FSMs: only advance on an audio tick, from registered latch/pend.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig_d  = trig_q;
    consume = '0;
    if (audio_clk_en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        case (state_q[i])
          ST_IDLE: begin
            if (latch_bits_q[i] || pend_q[i]) begin
              state_d[i] = ST_HOLD;
              trig_d[i]  = 1'b1;
              cnt_d[i]   = HOLD_LOAD;
              consume[i] = 1'b1;
            end
          end
          ST_HOLD: begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else if (latch_bits_q[i] && !pend_q[i]) begin
              state_d[i] = ST_FOLLOW;
            end else begin
              state_d[i] = ST_GAP;
              trig_d[i]  = 1'b0;
              cnt_d[i]   = GAP_LOAD;
            end
          end
          ST_FOLLOW: begin
            // A pending edge here means release plus re-press between ticks.
            if (!latch_bits_q[i] || pend_q[i]) begin
              state_d[i] = ST_GAP;
              trig_d[i]  = 1'b0;
              cnt_d[i]   = GAP_LOAD;
            end
          end
          ST_GAP: begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            trig_d[i]  = 1'b0;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Latch and sticky edge flags; a same-bit set overrides the channel's consume.
  always_comb begin
    latch_bits_d = latch_bits_q;
    pend_d       = pend_q & ~consume;
    if (cpu.latch_clr) begin
      latch_bits_d = '0;
      pend_d       = '0;
    end else if (cpu.cpu_wr) begin
      latch_bits_d[cpu.cpu_addr] = cpu.cpu_data;
      if (cpu.cpu_data && !latch_bits_q[cpu.cpu_addr]) begin
        pend_d[cpu.cpu_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      latch_bits_q <= '0;
      pend_q       <= '0;
      trig_q       <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      latch_bits_q <= latch_bits_d;
      pend_q       <= pend_d;
      trig_q       <= trig_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cpu.latch_q = latch_bits_q;
  assign trig_out    = trig_q;
  assign walk_en     = trig_q[WALK_IDX];

endmodule
